// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Elastic valid/ready pipeline register, STAGES slots deep, with
//               synchronous flush and control-field zeroing on bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 2,
    parameter int STAGES = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(STAGES+1)-1:0] occupancy
);

    localparam int c_OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] r_valid;
    logic [CTRL_W-1:0] r_ctrl [STAGES];
    logic [DATA_W-1:0] r_data [STAGES];
    logic [c_OCC_W-1:0] r_occ;

    logic [STAGES:0]   w_rdy;
    logic [STAGES-1:0] w_src_valid;
    logic [CTRL_W-1:0] w_src_ctrl [STAGES];
    logic [DATA_W-1:0] w_src_data [STAGES];
    logic              w_accept;
    logic              w_deliver;

    // Ready ripples back from the output so a stall releases without a bubble.
    always_comb begin
        w_rdy[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_rdy[i] = !r_valid[i] | w_rdy[i+1];
        end
    end

    always_comb begin
        w_src_valid[0] = in_valid;
        w_src_ctrl[0]  = in_ctrl;
        w_src_data[0]  = in_data;
        for (int i = 1; i < STAGES; i++) begin
            w_src_valid[i] = r_valid[i-1];
            w_src_ctrl[i]  = r_ctrl[i-1];
            w_src_data[i]  = r_data[i-1];
        end
    end

    assign w_accept  = in_valid & w_rdy[0];
    assign w_deliver = r_valid[STAGES-1] & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_ctrl[i] <= '0;
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_ctrl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (w_rdy[i]) begin
                    r_valid[i] <= w_src_valid[i];
                    r_ctrl[i]  <= w_src_valid[i] ? w_src_ctrl[i] : '0;
                    r_data[i]  <= w_src_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_accept && !w_deliver) begin
            r_occ <= r_occ + c_OCC_W'(1);
        end else if (w_deliver && !w_accept) begin
            r_occ <= r_occ - c_OCC_W'(1);
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_valid[STAGES-1];
    assign out_ctrl  = r_valid[STAGES-1] ? r_ctrl[STAGES-1] : '0;
    assign out_data  = r_data[STAGES-1];
    assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg (STAGES=3, 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ctrl;
    logic [68:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ctrl;
    logic [68:0] out_data;
    logic [1:0]  occupancy;

    logic        s1_flush;
    logic        s1_in_valid;
    logic        s1_in_ready;
    logic [1:0]  s1_in_ctrl;
    logic [68:0] s1_in_data;
    logic        s1_out_valid;
    logic        s1_out_ready;
    logic [1:0]  s1_out_ctrl;
    logic [68:0] s1_out_data;
    logic [0:0]  s1_occupancy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(69), .CTRL_W(2), .STAGES(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_stage_reg #(.DATA_W(69), .CTRL_W(2), .STAGES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (s1_flush),
        .in_valid  (s1_in_valid),
        .in_ready  (s1_in_ready),
        .in_ctrl   (s1_in_ctrl),
        .in_data   (s1_in_data),
        .out_valid (s1_out_valid),
        .out_ready (s1_out_ready),
        .out_ctrl  (s1_out_ctrl),
        .out_data  (s1_out_data),
        .occupancy (s1_occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 2'b00 || out_data !== 69'h0 || occupancy !== 2'd0) begin
            n_fail++;
            $display("FAIL reset3: valid=%b ctrl=%b data=%h occ=%0d, want all zero", out_valid, out_ctrl, out_data, occupancy);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset3_in_ready: got %b want 1", in_ready);
        end
        n_cmp++;
        if (s1_out_valid !== 1'b0 || s1_out_ctrl !== 2'b00 || s1_out_data !== 69'h0 || s1_occupancy !== 1'b0 || s1_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset1: valid=%b ctrl=%b data=%h occ=%0d rdy=%b, want 0/0/0/0/1", s1_out_valid, s1_out_ctrl, s1_out_data, s1_occupancy, s1_in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_throughput();
        logic [68:0] din   [5] = '{69'h11, 69'h22, 69'h33, 69'h55, 69'h66};
        logic        exp_v [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [68:0] exp_d [8] = '{69'h0, 69'h0, 69'h11, 69'h22, 69'h33, 69'h55, 69'h66, 69'h0};
        logic [1:0]  exp_o [8] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        logic [1:0]  exp_c;
        out_ready = 1'b1;
        flush     = 1'b0;
        in_ctrl   = 2'b01;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 5);
            if (c < 5) in_data = din[c];
            else       in_data = 69'h0;
            tick();
            exp_c = exp_v[c] ? 2'b01 : 2'b00;
            n_cmp++;
            if (out_valid !== exp_v[c] || occupancy !== exp_o[c] || out_ctrl !== exp_c ||
                (exp_v[c] && out_data !== exp_d[c])) begin
                n_fail++;
                $display("FAIL throughput cyc%0d: valid=%b ctrl=%b data=%h occ=%0d, want valid=%b ctrl=%b data=%h occ=%0d",
                         c, out_valid, out_ctrl, out_data, occupancy, exp_v[c], exp_c, exp_d[c], exp_o[c]);
            end
        end
    endtask

    task automatic test_stall();
        logic [68:0] exp_d [3] = '{69'hA2, 69'hA3, 69'hA4};
        logic [1:0]  exp_o [3] = '{2'd3, 2'd2, 2'd1};
        out_ready = 1'b0;
        in_ctrl   = 2'b01;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = 69'hA1 + 69'(c);
            tick();
        end
        in_data = 69'hA4;
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (in_ready !== 1'b0 || occupancy !== 2'd3 || out_valid !== 1'b1 || out_data !== 69'hA1 || out_ctrl !== 2'b01) begin
                n_fail++;
                $display("FAIL stall cyc%0d: rdy=%b occ=%0d valid=%b data=%h ctrl=%b, want 0/3/1/a1/01",
                         c, in_ready, occupancy, out_valid, out_data, out_ctrl);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp_d[c] || occupancy !== exp_o[c]) begin
                n_fail++;
                $display("FAIL stall_drain cyc%0d: valid=%b data=%h occ=%0d, want 1/%h/%0d",
                         c, out_valid, out_data, occupancy, exp_d[c], exp_o[c]);
            end
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_empty: valid=%b occ=%0d ctrl=%b, want 0/0/00", out_valid, occupancy, out_ctrl);
        end
    endtask

    task automatic test_bubble();
        logic        vin   [3] = '{1'b1, 1'b0, 1'b1};
        logic [1:0]  cin   [3] = '{2'b10, 2'b11, 2'b01};
        logic [68:0] dtin  [3] = '{69'hB1, 69'hFF, 69'hB3};
        logic        exp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0]  exp_c [6] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        logic [68:0] exp_d [6] = '{69'h0, 69'h0, 69'hB1, 69'h0, 69'hB3, 69'h0};
        logic [1:0]  exp_o [6] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0};
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                in_valid = vin[c];
                in_ctrl  = cin[c];
                in_data  = dtin[c];
            end else begin
                in_valid = 1'b0;
                in_ctrl  = 2'b11;
                in_data  = 69'hFF;
            end
            tick();
            n_cmp++;
            if (out_valid !== exp_v[c] || out_ctrl !== exp_c[c] || occupancy !== exp_o[c] ||
                (exp_v[c] && out_data !== exp_d[c])) begin
                n_fail++;
                $display("FAIL bubble cyc%0d: valid=%b ctrl=%b data=%h occ=%0d, want valid=%b ctrl=%b data=%h occ=%0d",
                         c, out_valid, out_ctrl, out_data, occupancy, exp_v[c], exp_c[c], exp_d[c], exp_o[c]);
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 2'b11;
        in_data   = 69'hC1;
        tick();
        in_data = 69'hC2;
        tick();
        n_cmp++;
        if (occupancy !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_pre_occ: got %0d want 2", occupancy);
        end
        in_data   = 69'h44;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 2'b00 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_state: valid=%b occ=%0d ctrl=%b rdy=%b, want 0/0/00/1", out_valid, occupancy, out_ctrl, in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
                n_fail++;
                $display("FAIL flush_after cyc%0d: valid=%b data=%h occ=%0d, want valid=0 occ=0", c, out_valid, out_data, occupancy);
            end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        in_ctrl   = 2'b11;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = 69'hD1 + 69'(c);
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (occupancy !== 2'd2 || out_valid !== 1'b1 || out_data !== 69'hD2 || out_ctrl !== 2'b11) begin
            n_fail++;
            $display("FAIL areset_pre: occ=%0d valid=%b data=%h ctrl=%b, want 2/1/d2/11", occupancy, out_valid, out_data, out_ctrl);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 2'b00 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_drop: valid=%b ctrl=%b occ=%0d rdy=%b, want 0/00/0/1", out_valid, out_ctrl, occupancy, in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 2'b10;
        in_data  = 69'hE1;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (occupancy !== 2'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_accept: occ=%0d valid=%b, want 1/0", occupancy, out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_mid: valid=%b want 0", out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 69'hE1 || out_ctrl !== 2'b10) begin
            n_fail++;
            $display("FAIL areset_first: valid=%b data=%h ctrl=%b, want 1/e1/10", out_valid, out_data, out_ctrl);
        end
        tick();
    endtask

    task automatic test_single_stage();
        s1_out_ready = 1'b1;
        s1_in_valid  = 1'b1;
        s1_in_ctrl   = 2'b10;
        for (int c = 0; c < 3; c++) begin
            s1_in_data = 69'h101 + 69'(c);
            tick();
            n_cmp++;
            if (s1_out_valid !== 1'b1 || s1_out_ctrl !== 2'b10 || s1_out_data !== (69'h101 + 69'(c)) || s1_occupancy !== 1'b1) begin
                n_fail++;
                $display("FAIL single cyc%0d: valid=%b ctrl=%b data=%h occ=%0d, want 1/10/%h/1",
                         c, s1_out_valid, s1_out_ctrl, s1_out_data, s1_occupancy, 69'h101 + 69'(c));
            end
        end
        s1_out_ready = 1'b0;
        #1;
        n_cmp++;
        if (s1_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_full_ready: got %b want 0", s1_in_ready);
        end
        s1_in_valid = 1'b0;
        s1_out_ready = 1'b1;
        tick();
        n_cmp++;
        if (s1_out_valid !== 1'b0 || s1_out_ctrl !== 2'b00 || s1_occupancy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_empty: valid=%b ctrl=%b occ=%0d, want 0/00/0", s1_out_valid, s1_out_ctrl, s1_occupancy);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_ctrl      = 2'b00;
        in_data      = 69'h0;
        out_ready    = 1'b0;
        s1_flush     = 1'b0;
        s1_in_valid  = 1'b0;
        s1_in_ctrl   = 2'b00;
        s1_in_data   = 69'h0;
        s1_out_ready = 1'b0;

        test_reset();
        test_throughput();
        test_stall();
        test_bubble();
        test_flush();
        test_async_reset();
        test_single_stage();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
`default_nettype wire
